// File: rtl/imm_decode_if.sv
// Handshake bundle between fetch, the immediate-decode stage and execute.
// The master side offers instructions and accepts results; the slave side
// is the decode stage itself.
interface imm_decode_if #(
  parameter int XLEN = 32
) ();
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_ir;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_ir;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic            out_illegal;

  modport master (
    output in_valid, in_ir, in_pc, out_ready,
    input  in_ready, out_valid, out_ir, out_pc, out_imm, out_fmt, out_illegal
  );

  modport slave (
    input  in_valid, in_ir, in_pc, out_ready,
    output in_ready, out_valid, out_ir, out_pc, out_imm, out_fmt, out_illegal
  );
endinterface

// File: rtl/imm_decode_stage.sv
// Registered RV32I/RV64I immediate-generation stage. The immediate, format
// code and illegal flag are decoded combinationally from the incoming word
// and captured with it into a 2-entry skid buffer (head + skid), so in_ready
// is a pure register and the stage sustains one instruction per cycle.
module imm_decode_stage #(
  parameter int XLEN     = 32,
  parameter bit FLUSH_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  imm_decode_if.slave  bus
);

  localparam logic [2:0] FMT_R     = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;
  localparam logic [2:0] FMT_NONE  = 3'd7;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  // Widen a 32-bit sign-correct immediate to XLEN by replicating bit 31.
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  // Widen a small unsigned field (shift amount) to XLEN with zeros.
  function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
    return XLEN'(v);
  endfunction

  logic [31:0] ir;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  logic [XLEN-1:0] imm_i_d, imm_s_d, imm_b_d, imm_u_d, imm_j_d;
  logic [XLEN-1:0] dec_imm_d;
  logic [2:0]      dec_fmt_d;
  logic            dec_ill_d;

  state_e state_q, state_d;
  logic   in_ready_q, out_valid_q;
  logic   accept, emit, flush_now;
  logic   take_new_d, take_skid_d, fill_skid_d;

  logic [31:0]     out_ir_q, skid_ir_q;
  logic [XLEN-1:0] out_pc_q, skid_pc_q;
  logic [XLEN-1:0] out_imm_q, skid_imm_q;
  logic [2:0]      out_fmt_q, skid_fmt_q;
  logic            out_illegal_q, skid_illegal_q;

  assign ir     = bus.in_ir;
  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign funct7 = ir[31:25];

  assign imm_i_d = sext32({{20{ir[31]}}, ir[31:20]});
  assign imm_s_d = sext32({{20{ir[31]}}, ir[31:25], ir[11:7]});
  assign imm_b_d = sext32({{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0});
  assign imm_u_d = sext32({ir[31:12], 12'b0});
  assign imm_j_d = sext32({{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0});

  // Decode format, immediate and legality of the word currently offered.
  always_comb begin
    dec_imm_d = '0;
    dec_fmt_d = FMT_NONE;
    dec_ill_d = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        dec_fmt_d = FMT_U;
        dec_imm_d = imm_u_d;
      end
      OPC_JAL: begin
        dec_fmt_d = FMT_J;
        dec_imm_d = imm_j_d;
      end
      OPC_JALR: begin
        dec_fmt_d = FMT_I;
        dec_imm_d = imm_i_d;
        dec_ill_d = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        dec_fmt_d = FMT_B;
        dec_imm_d = imm_b_d;
        dec_ill_d = (funct3[2:1] == 2'b01);
      end
      OPC_LOAD: begin
        dec_fmt_d = FMT_I;
        dec_imm_d = imm_i_d;
        case (funct3)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: dec_ill_d = 1'b0;
          3'b011, 3'b110:                         dec_ill_d = (XLEN != 64);
          default:                                dec_ill_d = 1'b1;
        endcase
      end
      OPC_STORE: begin
        dec_fmt_d = FMT_S;
        dec_imm_d = imm_s_d;
        case (funct3)
          3'b000, 3'b001, 3'b010: dec_ill_d = 1'b0;
          3'b011:                 dec_ill_d = (XLEN != 64);
          default:                dec_ill_d = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          // Shifts: RV64 borrows funct7[0] as shamt[5].
          dec_fmt_d = FMT_SHAMT;
          if (XLEN == 64) begin
            dec_imm_d = zext32({26'b0, ir[25:20]});
            dec_ill_d = !((ir[31:26] == 6'b000000) ||
                          (ir[31:26] == 6'b010000 && funct3 == 3'b101));
          end else begin
            dec_imm_d = zext32({27'b0, ir[24:20]});
            dec_ill_d = !((funct7 == 7'b0000000) ||
                          (funct7 == 7'b0100000 && funct3 == 3'b101));
          end
        end else begin
          dec_fmt_d = FMT_I;
          dec_imm_d = imm_i_d;
        end
      end
      OPC_OP: begin
        dec_fmt_d = FMT_R;
        dec_ill_d = !((funct7 == 7'b0000000) ||
                      (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)));
      end
      OPC_MISC: begin
        // FENCE (000) and FENCE.I (001) only.
        dec_fmt_d = FMT_NONE;
        dec_ill_d = (funct3[2:1] != 2'b00);
      end
      default: dec_ill_d = 1'b1;
    endcase
    if (dec_ill_d) begin
      dec_imm_d = '0;
      dec_fmt_d = FMT_NONE;
    end
  end

  assign flush_now = FLUSH_EN && flush;
  assign accept    = bus.in_valid && in_ready_q;
  assign emit      = out_valid_q && bus.out_ready;

  // Occupancy next-state and which buffer slot loads this cycle.
  always_comb begin
    state_d     = state_q;
    take_new_d  = 1'b0;
    take_skid_d = 1'b0;
    fill_skid_d = 1'b0;
    if (flush_now) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d    = ST_ONE;
            take_new_d = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && emit) begin
            take_new_d = 1'b1;
          end else if (accept) begin
            state_d     = ST_TWO;
            fill_skid_d = 1'b1;
          end else if (emit) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (emit) begin
            state_d     = ST_ONE;
            take_skid_d = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Occupancy state plus registered in_ready / out_valid derived from it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != ST_TWO);
      out_valid_q <= (state_d != ST_EMPTY);
    end
  end

  // Head entry: loads a fresh decode or promotes the skid entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_ir_q      <= '0;
      out_pc_q      <= '0;
      out_imm_q     <= '0;
      out_fmt_q     <= FMT_NONE;
      out_illegal_q <= 1'b0;
    end else if (take_new_d) begin
      out_ir_q      <= bus.in_ir;
      out_pc_q      <= bus.in_pc;
      out_imm_q     <= dec_imm_d;
      out_fmt_q     <= dec_fmt_d;
      out_illegal_q <= dec_ill_d;
    end else if (take_skid_d) begin
      out_ir_q      <= skid_ir_q;
      out_pc_q      <= skid_pc_q;
      out_imm_q     <= skid_imm_q;
      out_fmt_q     <= skid_fmt_q;
      out_illegal_q <= skid_illegal_q;
    end
  end

  // Skid entry: catches the word accepted while the head is stalled.
  always_ff @(posedge clk) begin
    if (fill_skid_d) begin
      skid_ir_q      <= bus.in_ir;
      skid_pc_q      <= bus.in_pc;
      skid_imm_q     <= dec_imm_d;
      skid_fmt_q     <= dec_fmt_d;
      skid_illegal_q <= dec_ill_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_ir      = out_ir_q;
  assign bus.out_pc      = out_pc_q;
  assign bus.out_imm     = out_imm_q;
  assign bus.out_fmt     = out_fmt_q;
  assign bus.out_illegal = out_illegal_q;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: directed scenarios plus a randomized run, all
// checked against a queue-based FIFO model with a spec-level decoder.
module tb_imm_decode_stage;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  always #5 clk = ~clk;

  imm_decode_if #(.XLEN(XLEN)) bus ();

  imm_decode_stage #(.XLEN(XLEN), .FLUSH_EN(1'b1)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0]     ir;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            ill;
  } ent_t;

  ent_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference decoder straight from the instruction-set rules.
  function automatic void ref_decode(input logic [31:0] ir, output logic [XLEN-1:0] imm,
                                     output logic [2:0] fmt, output logic ill);
    longint     v;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op = ir[6:0]; f3 = ir[14:12]; f7 = ir[31:25];
    v = 0; fmt = 3'd7; ill = 1'b0;
    case (op)
      7'h37, 7'h17: begin fmt = 3'd4; v = $signed(ir[31:12]) * 64'sd4096; end
      7'h6F: begin fmt = 3'd5; v = $signed({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}); end
      7'h67: begin fmt = 3'd1; v = $signed(ir[31:20]); ill = (f3 != 0); end
      7'h63: begin fmt = 3'd3; v = $signed({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0});
                   ill = (f3 == 2 || f3 == 3); end
      7'h03: begin fmt = 3'd1; v = $signed(ir[31:20]);
                   ill = !((f3 inside {0, 1, 2, 4, 5}) || (XLEN == 64 && (f3 inside {3, 6}))); end
      7'h23: begin fmt = 3'd2; v = $signed({ir[31:25], ir[11:7]});
                   ill = !((f3 inside {0, 1, 2}) || (XLEN == 64 && f3 == 3)); end
      7'h13: begin
        if (f3 == 1 || f3 == 5) begin
          fmt = 3'd6;
          if (XLEN == 64) begin
            v = ir[25:20];
            ill = !(ir[31:26] == 0 || (ir[31:26] == 6'h10 && f3 == 5));
          end else begin
            v = ir[24:20];
            ill = !(f7 == 0 || (f7 == 7'h20 && f3 == 5));
          end
        end else begin
          fmt = 3'd1; v = $signed(ir[31:20]);
        end
      end
      7'h33: begin fmt = 3'd0; v = 0; ill = !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5))); end
      7'h0F: begin fmt = 3'd7; v = 0; ill = !(f3 == 0 || f3 == 1); end
      default: ill = 1'b1;
    endcase
    if (ill) begin fmt = 3'd7; v = 0; end
    imm = v[XLEN-1:0];
  endfunction

  // Advance one clock; the model sees exactly what the DUT sees at the edge.
  task automatic tick(output bit acc);
    bit   emt, fl;
    ent_t e;
    acc  = bus.in_valid && (q.size() < 2);
    emt  = (q.size() > 0) && bus.out_ready;
    fl   = flush;
    e.ir = bus.in_ir;
    e.pc = bus.in_pc;
    ref_decode(bus.in_ir, e.imm, e.fmt, e.ill);
    @(posedge clk); #1;
    if (fl) begin
      q.delete();
      acc = 1'b0;
    end else begin
      if (emt) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
  endtask

  task automatic drain();
    bit acc;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) tick(acc);
  endtask

  task automatic test_reset();
    vectors++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL reset_handshake got valid/ready=%b exp 01", {bus.out_valid, bus.in_ready});
    end
    vectors++;
    if ({bus.out_ir, bus.out_pc, bus.out_imm, bus.out_fmt, bus.out_illegal} !==
        {32'd0, {XLEN{1'b0}}, {XLEN{1'b0}}, 3'd7, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_fields got ir=%h imm=%h fmt=%0d ill=%b exp ir=0 imm=0 fmt=7 ill=0",
               bus.out_ir, bus.out_imm, bus.out_fmt, bus.out_illegal);
    end
  endtask

  task automatic test_addi();
    bit acc;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_ir     = 32'hFFF00093;
    bus.in_pc     = XLEN'(32'h100);
    tick(acc);
    bus.in_valid = 1'b0;
    vectors++;
    if ({bus.out_valid, bus.out_imm, bus.out_fmt, bus.out_illegal} !==
        {1'b1, {XLEN{1'b1}}, 3'd1, 1'b0}) begin
      miscompares++;
      $display("FAIL addi got v=%b imm=%h fmt=%0d ill=%b exp v=1 imm=all-ones fmt=1 ill=0",
               bus.out_valid, bus.out_imm, bus.out_fmt, bus.out_illegal);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [31:0] irs  [4] = '{32'hFFDFF06F, 32'h00000463, 32'hFE002C23, 32'h123450B7};
    longint      imms [4] = '{-4, 8, -8, 64'h12345000};
    logic [2:0]  fmts [4] = '{3'd5, 3'd3, 3'd2, 3'd4};
    bit acc;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_ir    = irs[i];
      bus.in_pc    = XLEN'(32'h200 + 4 * i);
      tick(acc);
      vectors++;
      if ({bus.out_valid, bus.in_ready, bus.out_ir, bus.out_imm, bus.out_fmt} !==
          {1'b1, 1'b1, irs[i], XLEN'(imms[i]), fmts[i]}) begin
        miscompares++;
        $display("FAIL b2b_%0d got v=%b rdy=%b ir=%h imm=%h fmt=%0d exp v=1 rdy=1 ir=%h imm=%h fmt=%0d",
                 i, bus.out_valid, bus.in_ready, bus.out_ir, bus.out_imm, bus.out_fmt,
                 irs[i], XLEN'(imms[i]), fmts[i]);
      end
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [31:0] instr [3] = '{32'h00100093, 32'h00200113, 32'h00300193};
    logic [31:0] seen[$];
    int idx;
    bit acc;
    idx = 0;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      bus.in_valid = 1'b1;
      bus.in_ir    = instr[idx];
      bus.in_pc    = XLEN'(32'h300 + 4 * idx);
      tick(acc);
      if (acc) idx++;
      vectors++;
      if (bus.in_ready !== (q.size() < 2)) begin
        miscompares++;
        $display("FAIL bp_in_ready cyc%0d got %b exp %b", c, bus.in_ready, q.size() < 2);
      end
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_ir !== instr[0]) begin
        miscompares++;
        $display("FAIL bp_stable cyc%0d got v=%b ir=%h exp v=1 ir=%h", c, bus.out_valid, bus.out_ir, instr[0]);
      end
    end
    vectors++;
    if (bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_full got in_ready=%b exp 0", bus.in_ready);
    end
    bus.out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (idx < 3) begin
        bus.in_valid = 1'b1;
        bus.in_ir    = instr[idx];
        bus.in_pc    = XLEN'(32'h300 + 4 * idx);
      end else begin
        bus.in_valid = 1'b0;
      end
      if (bus.out_valid === 1'b1) seen.push_back(bus.out_ir);
      tick(acc);
      if (acc) idx++;
    end
    vectors++;
    if (seen.size() != 3) begin
      miscompares++;
      $display("FAIL bp_count got %0d exp 3", seen.size());
    end
    for (int i = 0; i < 3; i++) begin
      if (i < seen.size()) begin
        vectors++;
        if (seen[i] !== instr[i]) begin
          miscompares++;
          $display("FAIL bp_order_%0d got %h exp %h", i, seen[i], instr[i]);
        end
      end
    end
    drain();
  endtask

  task automatic test_illegal();
    logic [31:0] irs  [4] = '{32'h00000000, 32'h0200D093, 32'h00002063, 32'h4030D093};
    logic [2:0]  fmts [4] = '{3'd7, 3'd7, 3'd7, 3'd6};
    logic        ills [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    longint      imms [4] = '{0, 0, 0, 3};
    bit acc;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_ir    = irs[i];
      bus.in_pc    = XLEN'(32'h400 + 4 * i);
      tick(acc);
      bus.in_valid = 1'b0;
      vectors++;
      if ({bus.out_valid, bus.out_ir, bus.out_imm, bus.out_fmt, bus.out_illegal} !==
          {1'b1, irs[i], XLEN'(imms[i]), fmts[i], ills[i]}) begin
        miscompares++;
        $display("FAIL illegal_%0d got v=%b imm=%h fmt=%0d ill=%b exp v=1 imm=%h fmt=%0d ill=%b",
                 i, bus.out_valid, bus.out_imm, bus.out_fmt, bus.out_illegal,
                 XLEN'(imms[i]), fmts[i], ills[i]);
      end
      tick(acc);
    end
    drain();
  endtask

  task automatic test_flush();
    bit acc;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.in_ir    = 32'h00500093 + (i << 20);
      bus.in_pc    = XLEN'(32'h500 + 4 * i);
      tick(acc);
    end
    flush        = 1'b1;
    bus.in_ir    = 32'h00700093;
    bus.in_valid = 1'b1;
    tick(acc);
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    vectors++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL flush_state got valid/ready=%b exp 01", {bus.out_valid, bus.in_ready});
    end
    bus.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick(acc);
      vectors++;
      if (bus.out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL flush_leak cyc%0d got out_valid=%b ir=%h exp 0", c, bus.out_valid, bus.out_ir);
      end
    end
  endtask

  task automatic test_async_reset();
    bit acc;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_ir     = 32'h00A00093;
    bus.in_pc     = XLEN'(32'h600);
    tick(acc);
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    q.delete();
    vectors++;
    if ({bus.out_valid, bus.in_ready, bus.out_ir, bus.out_imm, bus.out_fmt, bus.out_illegal} !==
        {1'b0, 1'b1, 32'd0, {XLEN{1'b0}}, 3'd7, 1'b0}) begin
      miscompares++;
      $display("FAIL async_reset got v=%b rdy=%b ir=%h imm=%h fmt=%0d exp v=0 rdy=1 ir=0 imm=0 fmt=7",
               bus.out_valid, bus.in_ready, bus.out_ir, bus.out_imm, bus.out_fmt);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_ir     = 32'h00B00093;
    bus.in_pc     = XLEN'(32'h700);
    tick(acc);
    bus.in_valid = 1'b0;
    vectors++;
    if ({bus.out_valid, bus.out_ir, bus.out_imm} !== {1'b1, 32'h00B00093, XLEN'(32'd11)}) begin
      miscompares++;
      $display("FAIL post_reset got v=%b ir=%h imm=%h exp v=1 ir=00b00093 imm=b",
               bus.out_valid, bus.out_ir, bus.out_imm);
    end
    drain();
  endtask

  task automatic test_random();
    logic [6:0] ops [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F};
    logic [31:0] w;
    bit acc;
    for (int c = 0; c < 600; c++) begin
      w = $urandom;
      if ($urandom_range(7) != 0) w[6:0] = ops[$urandom_range(9)];
      if ($urandom_range(1) == 1) w[31:25] = ($urandom_range(1) == 1) ? 7'h20 : 7'h00;
      bus.in_ir     = w;
      bus.in_pc     = XLEN'($urandom);
      bus.in_valid  = ($urandom_range(3) != 0);
      bus.out_ready = ($urandom_range(2) != 0);
      flush         = ($urandom_range(24) == 0);
      tick(acc);
      flush = 1'b0;
      vectors++;
      if ({bus.out_valid, bus.in_ready} !== {q.size() > 0, q.size() < 2}) begin
        miscompares++;
        $display("FAIL rnd_ctrl cyc%0d got valid/ready=%b%b exp %b%b",
                 c, bus.out_valid, bus.in_ready, q.size() > 0, q.size() < 2);
      end
      if (q.size() > 0) begin
        vectors++;
        if ({bus.out_ir, bus.out_pc, bus.out_imm, bus.out_fmt, bus.out_illegal} !==
            {q[0].ir, q[0].pc, q[0].imm, q[0].fmt, q[0].ill}) begin
          miscompares++;
          $display("FAIL rnd_data cyc%0d got ir=%h imm=%h fmt=%0d ill=%b exp ir=%h imm=%h fmt=%0d ill=%b",
                   c, bus.out_ir, bus.out_imm, bus.out_fmt, bus.out_illegal,
                   q[0].ir, q[0].imm, q[0].fmt, q[0].ill);
        end
      end
    end
    drain();
  endtask

  initial begin
    rst           = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_ir     = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_addi();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_flush();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
